// File: rtl/fetch_stage.sv
// fetch_stage: owns the program counter, keeps at most one instruction-memory
// read in flight, and presents the fetched instruction and its PC to IF/ID.
// Responses belonging to fetches abandoned by a redirect are dropped in DRAIN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic        valid_F
);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcf_q, pcf_d;
  logic        valid_q, valid_d;

  logic        slot_free;
  logic        consumed;
  logic        issue;
  logic [31:0] redirect_tgt;

  // Output-slot occupancy and request issue decision
  always_comb begin
    consumed     = valid_q && !stall;
    slot_free    = !valid_q || !stall;
    issue        = reset && (state_q == ST_REQ) && slot_free && !redirect;
    redirect_tgt = redirect_pc & ~32'h0000_0003;
  end

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign Instr_F   = instr_q;
  assign PC_F      = pcf_q;
  assign valid_F   = valid_q;

  // Next-state logic: redirect first, then per-state fetch sequencing
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcf_d   = pcf_q;
    valid_d = valid_q;

    if (redirect) begin
      pc_d    = redirect_tgt;
      valid_d = 1'b0;
      case (state_q)
        // A response arriving with the redirect retires the outstanding
        // fetch, so nothing is left to drain (applies in DRAIN as well).
        ST_WAIT:  state_d = imem_rvalid ? ST_REQ : ST_DRAIN;
        ST_DRAIN: state_d = imem_rvalid ? ST_REQ : ST_DRAIN;
        default:  state_d = ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (issue) begin
            state_d = ST_WAIT;
            if (consumed) begin
              valid_d = 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            instr_d = imem_rdata;
            pcf_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = ST_REQ;
          end else if (consumed) begin
            valid_d = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (imem_rvalid) begin
            state_d = ST_REQ;
          end
        end
        default: begin
          state_d = ST_REQ;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pcf_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcf_q   <= pcf_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus a randomized run checked
// against a program-order model (expected PC stream, memory word = f(address)).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] Instr_F;
  logic [31:0] PC_F;
  logic        valid_F;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata = '0;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_valid;

  int checks = 0;
  int errors = 0;

  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  bit          mem_overlap = 1'b0;
  bit          inject_stale = 1'b0;
  bit          w_pend = 1'b0;
  logic [31:0] w_paddr = '0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .Instr_F(Instr_F), .PC_F(PC_F), .valid_F(valid_F)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0000_0000), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .Instr_F(w_instr), .PC_F(w_pc), .valid_F(w_valid)
  );

  always #5 clk = ~clk;

  // Memory contents: word at address a is ((a/4)+1)*0x11, so 0->0x11, 4->0x22, 8->0x33
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  // Main instruction memory: latency mem_lat cycles, shares reset, flags overlapping requests
  always @(posedge clk) begin
    int old;
    #2;
    if (!reset) begin
      mem_cnt     = 0;
      imem_rvalid = 1'b0;
    end else begin
      old = mem_cnt;
      imem_rvalid = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt = mem_cnt - 1;
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(mem_addr);
        end
      end
      if (inject_stale) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
      end
      if (imem_req) begin
        if (old > 0) mem_overlap = 1'b1;
        mem_cnt  = mem_lat;
        mem_addr = imem_addr;
      end
    end
  end

  // Single-cycle memory for the wrap-around instance
  always @(posedge clk) begin
    #2;
    if (!reset) begin
      w_pend   = 1'b0;
      w_rvalid = 1'b0;
    end else begin
      w_rvalid = w_pend;
      w_rdata  = mem_word(w_paddr);
      w_pend   = w_req;
      w_paddr  = w_addr;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (Instr_F !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", Instr_F); end
    checks++; if (PC_F !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", PC_F); end
    checks++; if (valid_F !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_F); end
  endtask

  task automatic test_wrap();
    cyc(); reset = 1'b1;
    @(negedge clk);
    checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req0: got req=%b addr=%h expected req=1 addr=fffffffc", w_req, w_addr); end
    cyc(); cyc();
    @(negedge clk);
    checks++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_instr !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_out0: got v=%b pc=%h instr=%h expected v=1 pc=fffffffc instr=%h", w_valid, w_pc, w_instr, mem_word(32'hFFFF_FFFC)); end
    checks++; if (w_req !== 1'b1 || w_addr !== 32'h0) begin errors++; $display("FAIL wrap_req1: got req=%b addr=%h expected req=1 addr=00000000", w_req, w_addr); end
    cyc(); cyc();
    @(negedge clk);
    checks++; if (w_valid !== 1'b1 || w_pc !== 32'h0 || w_instr !== 32'h11) begin errors++; $display("FAIL wrap_out1: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=11", w_valid, w_pc, w_instr); end
    cyc(); reset = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 0) reset = 1'b1;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL basic_req%0d: got req=%b addr=%h expected req=1 addr=%h", k, imem_req, imem_addr, 32'(4 * k)); end
      if (k > 0) begin
        checks++; if (valid_F !== 1'b1 || Instr_F !== 32'(17 * k) || PC_F !== 32'(4 * (k - 1))) begin errors++; $display("FAIL basic_out%0d: got v=%b instr=%h pc=%h expected v=1 instr=%h pc=%h", k, valid_F, Instr_F, PC_F, 32'(17 * k), 32'(4 * (k - 1))); end
      end
      if (k < 3) begin
        cyc();
        @(negedge clk);
        checks++; if (imem_req !== 1'b0 || valid_F !== 1'b0) begin errors++; $display("FAIL basic_wait%0d: got req=%b v=%b expected req=0 v=0", k, imem_req, valid_F); end
      end
    end
  endtask

  task automatic test_redirect_rvalid();
    cyc(); redirect = 1'b1; redirect_pc = 32'h0000_0004;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rr_req_during: got %b expected 0", imem_req); end
    cyc(); redirect = 1'b0;
    @(negedge clk);
    checks++; if (valid_F !== 1'b0) begin errors++; $display("FAIL rr_valid: got %b expected 0", valid_F); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL rr_req_next: got req=%b addr=%h expected req=1 addr=00000004", imem_req, imem_addr); end
  endtask

  task automatic test_stall();
    cyc();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_wait: got req=%b expected 0", imem_req); end
    for (int i = 0; i < 3; i++) begin
      cyc(); stall = 1'b1;
      @(negedge clk);
      checks++; if (valid_F !== 1'b1 || Instr_F !== 32'h22 || PC_F !== 32'h4) begin errors++; $display("FAIL stall_hold%0d: got v=%b instr=%h pc=%h expected v=1 instr=22 pc=4", i, valid_F, Instr_F, PC_F); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req%0d: got %b expected 0", i, imem_req); end
    end
    cyc(); stall = 1'b0; mem_lat = 3;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL stall_release: got req=%b addr=%h expected req=1 addr=00000008", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_drain();
    cyc(); redirect = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drain_req0: got %b expected 0", imem_req); end
    cyc(); redirect = 1'b0;
    @(negedge clk);
    checks++; if (valid_F !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL drain_wait1: got v=%b req=%b expected v=0 req=0", valid_F, imem_req); end
    cyc(); mem_lat = 1;
    @(negedge clk);
    checks++; if (valid_F !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL drain_wait2: got v=%b req=%b expected v=0 req=0", valid_F, imem_req); end
    cyc();
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || valid_F !== 1'b0) begin errors++; $display("FAIL drain_target_req: got req=%b addr=%h v=%b expected req=1 addr=00000100 v=0", imem_req, imem_addr, valid_F); end
    cyc();
    @(negedge clk);
    checks++; if (valid_F !== 1'b0) begin errors++; $display("FAIL drain_target_wait: got v=%b expected 0", valid_F); end
    cyc(); mem_lat = 3;
    @(negedge clk);
    checks++; if (valid_F !== 1'b1 || PC_F !== 32'h100 || Instr_F !== 32'h451) begin errors++; $display("FAIL drain_target_out: got v=%b pc=%h instr=%h expected v=1 pc=00000100 instr=00000451", valid_F, PC_F, Instr_F); end
  endtask

  task automatic test_reset_in_wait();
    cyc(); reset = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_req_in_reset: got %b expected 0", imem_req); end
    cyc();
    @(negedge clk);
    checks++; if (Instr_F !== 32'h0 || PC_F !== 32'h0 || valid_F !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rw_outputs: got instr=%h pc=%h v=%b req=%b expected all 0", Instr_F, PC_F, valid_F, imem_req); end
    cyc(); reset = 1'b1; inject_stale = 1'b1; mem_lat = 1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rw_first_req: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
    cyc(); inject_stale = 1'b0;
    @(negedge clk);
    checks++; if (valid_F !== 1'b0) begin errors++; $display("FAIL rw_stale: got v=%b expected 0", valid_F); end
    cyc();
    @(negedge clk);
    checks++; if (valid_F !== 1'b1 || PC_F !== 32'h0 || Instr_F !== 32'h11) begin errors++; $display("FAIL rw_first_out: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=11", valid_F, PC_F, Instr_F); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    bit          prev_hold;
    int          consumed;
    cyc(); reset = 1'b0; stall = 1'b0; redirect = 1'b0;
    cyc(); reset = 1'b1;
    exp_pc    = 32'h0;
    prev_hold = 1'b0;
    prev_pc   = '0;
    prev_instr = '0;
    consumed  = 0;
    for (int n = 0; n < 2000; n++) begin
      cyc();
      stall       = ($urandom_range(0, 9) < 3);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      mem_lat     = $urandom_range(1, 3);
      @(negedge clk);
      if (prev_hold) begin
        checks++; if (valid_F !== 1'b1 || PC_F !== prev_pc || Instr_F !== prev_instr) begin errors++; $display("FAIL rnd_hold @%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", n, valid_F, PC_F, Instr_F, prev_pc, prev_instr); end
      end
      if (redirect || (valid_F && stall)) begin
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rnd_blocked_req @%0d: got %b expected 0", n, imem_req); end
      end
      if (redirect) begin
        exp_pc = redirect_pc & ~32'h3;
      end else if (valid_F === 1'b1 && !stall) begin
        checks++; if (PC_F !== exp_pc || Instr_F !== mem_word(exp_pc)) begin errors++; $display("FAIL rnd_consume @%0d: got pc=%h instr=%h expected pc=%h instr=%h", n, PC_F, Instr_F, exp_pc, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      prev_hold  = valid_F && stall && !redirect;
      prev_pc    = PC_F;
      prev_instr = Instr_F;
    end
    cyc(); stall = 1'b0; redirect = 1'b0;
    checks++; if (consumed < 150) begin errors++; $display("FAIL rnd_progress: got %0d instructions expected at least 150", consumed); end
    checks++; if (mem_overlap !== 1'b0) begin errors++; $display("FAIL one_outstanding: got overlap=%b expected 0", mem_overlap); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_wrap();
    test_basic();
    test_redirect_rvalid();
    test_stall();
    test_redirect_drain();
    test_reset_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
